// File: rtl/dpe_pkg.sv
// Shared definitions for the dot-product responder: widths, FSM encoding and
// the saturating narrow from the wide accumulator to the result width.
package dpe_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 10;
   localparam int ACC_W  = 74;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } state_t;

   // In range exactly when every bit from the result sign bit upward agrees.
   function automatic logic [DATA_W-1:0] sat_to_data(input logic [ACC_W-1:0] acc);
      logic [ACC_W-DATA_W:0] upper;
      upper = acc[ACC_W-1:DATA_W-1];
      if (&upper || ~|upper)
         return acc[DATA_W-1:0];
      else if (acc[ACC_W-1])
         return {1'b1, {(DATA_W-1){1'b0}}};
      else
         return {1'b0, {(DATA_W-1){1'b1}}};
   endfunction

endpackage

// File: rtl/dpe_mac_unit.sv
// Signed multiply-accumulate: full-width product sign-extended into a wide
// accumulator that cannot overflow for the longest vector.
module dpe_mac_unit
   import dpe_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc
);

   logic signed [2*DATA_W-1:0] prod;
   logic        [ACC_W-1:0]    prod_ext;

   assign prod     = $signed(a) * $signed(b);
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (clear)
         acc <= '0;
      else if (en)
         acc <= acc + prod_ext;
   end

endmodule

// File: rtl/dot_product_responder.sv
// Responder for the start/addr/data/done dot-product handshake: walks the
// operand buffers, accumulates signed products and returns a saturated sum.
module dot_product_responder
   import dpe_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] vec_length,
   input  logic [DATA_W-1:0] patch_data,
   input  logic [DATA_W-1:0] filter_data,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic [ADDR_W-1:0] patch_addr,
   output logic [ADDR_W-1:0] filter_addr,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   state_t            state, next_state;
   logic [ADDR_W-1:0] len;
   logic [ADDR_W-1:0] idx;
   logic              issue_vld_d1;
   logic              accept;
   logic              issuing;
   logic              last_issue;
   logic [ACC_W-1:0]  acc;

   // Handshake: a start is taken only in IDLE and not in the done cycle;
   // data for the address shown in cycle t is consumed at the end of cycle t+1.
   assign accept      = (state == IDLE) && start && !done;
   assign issuing     = (state == ISSUE);
   assign last_issue  = issuing && (idx == len - ADDR_W'(1));
   assign patch_addr  = idx;
   assign filter_addr = idx;
   assign dbg_state   = state;

   // An empty vector still spends the drain cycle so every run costs L+3 cycles.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = (vec_length == '0) ? DRAIN : ISSUE;
         ISSUE:   if (last_issue) next_state = DRAIN;
         DRAIN:   next_state = FINISH;
         FINISH:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         len          <= '0;
         idx          <= '0;
         issue_vld_d1 <= 1'b0;
         done         <= 1'b0;
         result       <= '0;
         busy         <= 1'b0;
      end else begin
         state        <= next_state;
         issue_vld_d1 <= issuing;
         done         <= (state == FINISH);
         if (accept) begin
            len  <= vec_length;
            idx  <= '0;
            busy <= 1'b1;
         end else if (done) begin
            busy <= 1'b0;
         end
         // Address returns to 0 after the last element; it never wraps.
         if (issuing)
            idx <= last_issue ? '0 : idx + ADDR_W'(1);
         if (state == FINISH)
            result <= sat_to_data(acc);
      end
   end

   dpe_mac_unit u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (accept),
      .en    (issue_vld_d1),
      .a     (patch_data),
      .b     (filter_data),
      .acc   (acc)
   );

endmodule

// File: tb/tb_dot_product_responder.sv
// Bench for dot_product_responder: one-cycle buffer model, result scoreboard,
// latency/busy/address checks per scenario.
module tb_dot_product_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [9:0]  vec_length;
   logic [31:0] patch_data;
   logic [31:0] filter_data;
   logic        done;
   logic [31:0] result;
   logic [9:0]  patch_addr;
   logic [9:0]  filter_addr;
   logic        busy;
   logic [1:0]  dbg_state;

   localparam logic signed [79:0] S_MAX = 80'sd2147483647;
   localparam logic signed [79:0] S_MIN = -80'sd2147483648;

   logic [31:0] a_mem [0:1023];
   logic [31:0] b_mem [0:1023];
   logic [31:0] exp_q [$];
   logic [31:0] exp_v;

   int errors   = 0;
   int checks   = 0;
   int done_cnt = 0;
   int busy_cyc;
   int max_addr;
   bit addr_split;
   logic [9:0] addr_log [0:15];

   always #5 clk = ~clk;

   dot_product_responder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .vec_length  (vec_length),
      .patch_data  (patch_data),
      .filter_data (filter_data),
      .done        (done),
      .result      (result),
      .patch_addr  (patch_addr),
      .filter_addr (filter_addr),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   // Matrix-engine buffers: address in cycle t gives data in cycle t+1.
   always @(posedge clk) begin
      patch_data  <= a_mem[patch_addr];
      filter_data <= b_mem[filter_addr];
   end

   // Scoreboard: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got done with result %h, required no done", result);
         end else begin
            exp_v = exp_q.pop_front();
            if (result !== exp_v) begin
               errors++;
               $display("FAIL scoreboard_result: got %h, required %h", result, exp_v);
            end
         end
      end
   end

   function automatic logic [31:0] dot_model(input int len);
      logic signed [79:0] s;
      s = '0;
      for (int i = 0; i < len; i++)
         s = s + $signed(a_mem[i]) * $signed(b_mem[i]);
      if (s > S_MAX) return 32'h7FFF_FFFF;
      if (s < S_MIN) return 32'h8000_0000;
      return s[31:0];
   endfunction

   task automatic sample(input int cyc);
      if (busy) busy_cyc++;
      if (cyc < 16) addr_log[cyc] = patch_addr;
      if (int'(patch_addr) > max_addr) max_addr = int'(patch_addr);
      if (patch_addr !== filter_addr) addr_split = 1'b1;
   endtask

   task automatic start_vec(input int len);
      @(negedge clk);
      start      = 1'b1;
      vec_length = 10'(len);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Cycle 1 is the cycle right after the edge that sampled start.
   task automatic wait_done(input bit first, output int cyc);
      cyc        = first ? 1 : 0;
      busy_cyc   = 0;
      max_addr   = 0;
      addr_split = 1'b0;
      for (int i = 0; i < 16; i++) addr_log[i] = '0;
      if (first) sample(cyc);
      while ((cyc == 0 || !done) && cyc < 2000) begin
         @(posedge clk);
         #1;
         cyc++;
         sample(cyc);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles, required done", cyc);
      end
   endtask

   task automatic run_vec(input int len, input string tag);
      int cyc;
      int exp_max;
      exp_q.push_back(dot_model(len));
      start_vec(len);
      wait_done(1'b1, cyc);
      checks++;
      if (cyc != len + 3) begin
         errors++;
         $display("FAIL %s_latency: got done in cycle %0d, required %0d", tag, cyc, len + 3);
      end
      checks++;
      if (busy_cyc != len + 3) begin
         errors++;
         $display("FAIL %s_busy: got %0d busy cycles, required %0d", tag, busy_cyc, len + 3);
      end
      exp_max = (len == 0) ? 0 : len - 1;
      checks++;
      if (max_addr != exp_max) begin
         errors++;
         $display("FAIL %s_max_addr: got %0d, required %0d", tag, max_addr, exp_max);
      end
      checks++;
      if (addr_split) begin
         errors++;
         $display("FAIL %s_addr_equal: got filter_addr differing from patch_addr, required equal", tag);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_pulse_end: got done=%b busy=%b, required 0 0", tag, done, busy);
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      start      = 1'b0;
      vec_length = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({done, busy, result, patch_addr, filter_addr, dbg_state} !== '0) begin
         errors++;
         $display("FAIL reset_state: got done=%b busy=%b result=%h pa=%0d fa=%0d st=%0d, required all 0",
                  done, busy, result, patch_addr, filter_addr, dbg_state);
      end
   endtask

   task automatic test_basic();
      a_mem[0] = 32'd1; a_mem[1] = 32'd2;
      b_mem[0] = 32'd3; b_mem[1] = 32'd4;
      run_vec(2, "basic");
      checks++;
      if (addr_log[1] !== 10'd0 || addr_log[2] !== 10'd1 || addr_log[3] !== 10'd0) begin
         errors++;
         $display("FAIL basic_addr_seq: got %0d,%0d,%0d, required 0,1,0", addr_log[1], addr_log[2], addr_log[3]);
      end
      checks++;
      if (result !== 32'd11) begin
         errors++;
         $display("FAIL basic_result: got %0d, required 11", result);
      end
   endtask

   task automatic test_zero_len();
      run_vec(0, "zero_len");
      checks++;
      if (result !== 32'd0) begin
         errors++;
         $display("FAIL zero_len_result: got %h, required 0", result);
      end
   endtask

   task automatic test_signed();
      a_mem[0] = -32'sd5; a_mem[1] = 32'sd7;  a_mem[2] = 32'sd0;
      b_mem[0] = 32'sd6;  b_mem[1] = -32'sd2; b_mem[2] = 32'sd9;
      run_vec(3, "signed");
      checks++;
      if (result !== 32'hFFFF_FFD4) begin
         errors++;
         $display("FAIL signed_result: got %h, required ffffffd4", result);
      end
   endtask

   task automatic test_saturation();
      a_mem[0] = 32'h7FFF_FFFF; a_mem[1] = 32'h7FFF_FFFF;
      b_mem[0] = 32'h7FFF_FFFF; b_mem[1] = 32'h7FFF_FFFF;
      run_vec(2, "sat_pos");
      checks++;
      if (result !== 32'h7FFF_FFFF) begin
         errors++;
         $display("FAIL sat_pos_result: got %h, required 7fffffff", result);
      end
      a_mem[0] = 32'h8000_0000; a_mem[1] = 32'h8000_0000;
      run_vec(2, "sat_neg");
      checks++;
      if (result !== 32'h8000_0000) begin
         errors++;
         $display("FAIL sat_neg_result: got %h, required 80000000", result);
      end
   endtask

   task automatic test_protocol();
      int cyc;
      int d0;
      // Start pulsed mid-vector with a different length must be ignored.
      for (int i = 0; i < 8; i++) begin
         a_mem[i] = 32'($urandom_range(200)) - 32'd100;
         b_mem[i] = 32'($urandom_range(200)) - 32'd100;
      end
      d0 = done_cnt;
      exp_q.push_back(dot_model(3));
      start_vec(3);
      start      = 1'b1;
      vec_length = 10'd7;
      @(posedge clk);
      #1;
      start      = 1'b0;
      vec_length = 10'd0;
      wait_done(1'b0, cyc);
      checks++;
      if (cyc != 4) begin
         errors++;
         $display("FAIL ignore_start_latency: got %0d more cycles, required 4", cyc);
      end
      repeat (10) @(posedge clk);
      checks++;
      if (done_cnt != d0 + 1) begin
         errors++;
         $display("FAIL ignore_start_pulses: got %0d done pulses, required 1", done_cnt - d0);
      end
      // Asynchronous reset in ISSUE aborts the vector.
      d0 = done_cnt;
      start_vec(4);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      checks++;
      if ({done, busy, result, patch_addr, filter_addr, dbg_state} !== '0) begin
         errors++;
         $display("FAIL async_reset: got done=%b busy=%b result=%h pa=%0d st=%0d, required all 0",
                  done, busy, result, patch_addr, dbg_state);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      checks++;
      if (done_cnt != d0) begin
         errors++;
         $display("FAIL reset_no_done: got %0d done pulses, required 0", done_cnt - d0);
      end
      a_mem[0] = 32'd9;
      b_mem[0] = 32'd9;
      run_vec(1, "after_reset");
      checks++;
      if (result !== 32'd81) begin
         errors++;
         $display("FAIL after_reset_result: got %0d, required 81", result);
      end
   endtask

   task automatic test_max_len();
      for (int i = 0; i < 1023; i++) begin
         a_mem[i] = 32'd1;
         b_mem[i] = 32'd2;
      end
      run_vec(1023, "max_len");
      checks++;
      if (result !== 32'd2046) begin
         errors++;
         $display("FAIL max_len_result: got %0d, required 2046", result);
      end
   endtask

   task automatic load_pair(input int k);
      logic [31:0] ma [0:3];
      logic [31:0] mb [0:3];
      int r;
      int c;
      ma = '{32'd1, 32'd2, 32'd3, 32'd4};
      mb = '{32'd5, 32'd6, 32'd7, 32'd8};
      r = k / 2;
      c = k % 2;
      a_mem[0] = ma[r*2];
      a_mem[1] = ma[r*2+1];
      b_mem[0] = mb[c];
      b_mem[1] = mb[2+c];
      exp_q.push_back(dot_model(2));
   endtask

   // Start held high re-triggers each vector on the cycle after done.
   task automatic test_back_to_back();
      logic [31:0] c_exp [0:3];
      int cyc;
      c_exp = '{32'd19, 32'd22, 32'd43, 32'd50};
      load_pair(0);
      @(negedge clk);
      start      = 1'b1;
      vec_length = 10'd2;
      wait_done(1'b0, cyc);
      checks++;
      if (cyc != 5) begin
         errors++;
         $display("FAIL b2b_first_latency: got %0d, required 5", cyc);
      end
      for (int k = 1; k < 4; k++) begin
         checks++;
         if (result !== c_exp[k-1]) begin
            errors++;
            $display("FAIL b2b_c%0d: got %0d, required %0d", k - 1, result, c_exp[k-1]);
         end
         load_pair(k);
         wait_done(1'b0, cyc);
         checks++;
         if (cyc != 6) begin
            errors++;
            $display("FAIL b2b_gap%0d: got %0d cycles done-to-done, required 6", k, cyc);
         end
      end
      start = 1'b0;
      checks++;
      if (result !== c_exp[3]) begin
         errors++;
         $display("FAIL b2b_c3: got %0d, required %0d", result, c_exp[3]);
      end
      repeat (10) @(posedge clk);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         a_mem[i] = '0;
         b_mem[i] = '0;
      end
      test_reset();
      test_basic();
      test_zero_len();
      test_signed();
      test_saturation();
      test_protocol();
      test_max_len();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending results, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
